adc_readout_fsm: RTL and testbench

Readout-side controller for imager #1, clocked on CLK_HS. It answers the exposure FSM's `FSMIND1` request and acknowledges it, then sequences row selection and ADC start/latch for every pixel row. When the frame is read out, it hands control back through the `FSMIND0`/`FSMIND0ACK` handshake. It is the MOBO-side counterpart of the exposure/mask-streaming FSM in the CLKMPRE domain.

---
 rtl/readout_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/adc_readout_fsm.sv | 111 +++++++++++
 tb/tb_adc_readout_fsm.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/readout_pkg.sv
// Shared definitions for the imager readout controller: state codes double as
// the fsm_stat encoding, plus the default conversion time.
package readout_pkg;

  localparam int T_CONV_DEF = 16;

  typedef enum logic [7:0] {
    ST_IDLE     = 8'hF1,
    ST_SETTLE   = 8'hF2,
    ST_START    = 8'hF4,
    ST_CONV     = 8'hF8,
    ST_LATCH    = 8'hF0,
    ST_HANDBACK = 8'hE0
  } state_t;

  // Settle of 0 behaves as 1; the counter runs from load value down to 0.
  function automatic logic [15:0] settle_load(input logic [15:0] s);
    return (s == 16'd0) ? 16'd0 : s - 16'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with synchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/adc_readout_fsm.sv
// Readout controller: accepts the exposure request, walks every pixel row through
// settle / ADC start / conversion / latch, then hands control back.
module adc_readout_fsm
  import readout_pkg::*;
#(
  parameter int C_NUM_ROWS = 160,
  parameter int C_T_CONV   = T_CONV_DEF,
  parameter int C_ROW_W    = 8
) (
  input  logic               CLK_HS,
  input  logic               RESET,
  input  logic               FSMIND1,
  output logic               FSMIND1ACK,
  output logic               FSMIND0,
  input  logic               FSMIND0ACK,
  input  logic [15:0]        Settle,
  output logic               ROW_EN,
  output logic [C_ROW_W-1:0] ROW_ADDR,
  output logic               ADC_START,
  output logic               ADC_LATCH,
  output logic [31:0]        FrameCnt,
  output logic [7:0]         fsm_stat
);

  localparam logic [15:0]        CONV_LOAD = 16'(C_T_CONV - 1);
  localparam logic [C_ROW_W-1:0] LAST_ROW  = C_ROW_W'(C_NUM_ROWS - 1);
  localparam logic [C_ROW_W-1:0] ROW_ONE   = C_ROW_W'(1);

  state_t               state, state_n;
  logic [C_ROW_W-1:0]   row, row_n;
  logic [15:0]          cnt, cnt_n;
  logic [31:0]          frame_cnt;
  logic                 frame_done;
  logic                 active_n;
  logic                 s_ind1, s_ack0;

  sync_2ff u_sync_ind1 (.clk(CLK_HS), .rst(RESET), .d(FSMIND1),    .q(s_ind1));
  sync_2ff u_sync_ack0 (.clk(CLK_HS), .rst(RESET), .d(FSMIND0ACK), .q(s_ack0));

  always_comb begin
    state_n    = state;
    row_n      = row;
    cnt_n      = cnt;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: if (s_ind1) begin
        row_n   = '0;
        cnt_n   = settle_load(Settle);
        state_n = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt == 16'd0) state_n = ST_START;
        else              cnt_n   = cnt - 16'd1;
      end
      ST_START: begin
        cnt_n   = CONV_LOAD;
        state_n = ST_CONV;
      end
      ST_CONV: begin
        if (cnt == 16'd0) state_n = ST_LATCH;
        else              cnt_n   = cnt - 16'd1;
      end
      ST_LATCH: begin
        if (row == LAST_ROW) begin
          frame_done = 1'b1;
          state_n    = ST_HANDBACK;
        end else begin
          row_n   = row + ROW_ONE;
          cnt_n   = settle_load(Settle);
          state_n = ST_SETTLE;
        end
      end
      // Exit needs the request withdrawn too, so a held FSMIND0ACK can't end it early.
      ST_HANDBACK: if (s_ack0 && !s_ind1) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    active_n = (state_n == ST_SETTLE) || (state_n == ST_START) ||
               (state_n == ST_CONV)   || (state_n == ST_LATCH);
  end

  // Outputs are registered decodes of the next state, so they line up with fsm_stat.
  always_ff @(posedge CLK_HS) begin
    if (RESET) begin
      state      <= ST_IDLE;
      row        <= '0;
      cnt        <= '0;
      frame_cnt  <= '0;
      ROW_EN     <= 1'b0;
      ROW_ADDR   <= '0;
      ADC_START  <= 1'b0;
      ADC_LATCH  <= 1'b0;
      FSMIND0    <= 1'b0;
      FSMIND1ACK <= 1'b0;
    end else begin
      state      <= state_n;
      row        <= row_n;
      cnt        <= cnt_n;
      if (frame_done) frame_cnt <= frame_cnt + 32'd1;
      ROW_EN     <= active_n;
      ROW_ADDR   <= active_n ? row_n : '0;
      ADC_START  <= (state_n == ST_START);
      ADC_LATCH  <= (state_n == ST_LATCH);
      FSMIND0    <= (state_n == ST_HANDBACK);
      FSMIND1ACK <= (state_n != ST_IDLE);
    end
  end

  assign FrameCnt = frame_cnt;
  assign fsm_stat = state;

endmodule

// File: tb/tb_adc_readout_fsm.sv
// Randomized bench for adc_readout_fsm against a timeline model of each row.
module tb_adc_readout_fsm;

  localparam int N = 160;
  localparam int T = 16;

  logic        CLK_HS = 1'b0;
  logic        RESET = 1'b1;
  logic        FSMIND1 = 1'b0;
  logic        FSMIND0ACK = 1'b0;
  logic [15:0] Settle = 16'd4;
  logic        FSMIND1ACK, FSMIND0, ROW_EN, ADC_START, ADC_LATCH;
  logic [7:0]  ROW_ADDR, fsm_stat;
  logic [31:0] FrameCnt;

  adc_readout_fsm #(.C_NUM_ROWS(N), .C_T_CONV(T), .C_ROW_W(8)) dut (
    .CLK_HS(CLK_HS), .RESET(RESET), .FSMIND1(FSMIND1), .FSMIND1ACK(FSMIND1ACK),
    .FSMIND0(FSMIND0), .FSMIND0ACK(FSMIND0ACK), .Settle(Settle), .ROW_EN(ROW_EN),
    .ROW_ADDR(ROW_ADDR), .ADC_START(ADC_START), .ADC_LATCH(ADC_LATCH),
    .FrameCnt(FrameCnt), .fsm_stat(fsm_stat)
  );

  always #5 CLK_HS = ~CLK_HS;

  int total = 0, bad = 0, cyc = 0;
  bit chk_en = 1'b0;

  // model: mode 0 idle, 1 reading rows, 2 waiting for handback
  int m_mode = 0, m_row = 0, m_pos = 0, m_s = 1;
  logic [31:0] m_cnt = '0;
  bit sa1, sb1, sa0, sb0;
  int n_start = 0, n_latch = 0;
  int row_len [N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  function automatic int eff(input logic [15:0] s);
    return (s == 16'd0) ? 1 : int'(s);
  endfunction

  // Compare current DUT outputs with the model, then advance the model by the
  // coming clock edge using the inputs that edge will see.
  task automatic model_step();
    logic [7:0] e_stat;
    bit e_en, e_st, e_lt, s1, s0;
    cyc++;
    e_en = (m_mode == 1);
    e_st = e_en && (m_pos == m_s);
    e_lt = e_en && (m_pos == m_s + T + 1);
    if (m_mode == 0)              e_stat = 8'hF1;
    else if (m_mode == 2)         e_stat = 8'hE0;
    else if (m_pos < m_s)         e_stat = 8'hF2;
    else if (m_pos == m_s)        e_stat = 8'hF4;
    else if (m_pos <= m_s + T)    e_stat = 8'hF8;
    else                          e_stat = 8'hF0;
    if (chk_en)
      chk("cycle", {ROW_EN, ROW_ADDR, ADC_START, ADC_LATCH, FSMIND0, FSMIND1ACK, fsm_stat, FrameCnt},
          {e_en, e_en ? 8'(m_row) : 8'h00, e_st, e_lt, m_mode == 2, m_mode != 0, e_stat, m_cnt});
    if (ROW_EN === 1'b1 && ROW_ADDR < 8'(N)) row_len[ROW_ADDR]++;
    if (ADC_START === 1'b1) n_start++;
    if (ADC_LATCH === 1'b1) n_latch++;
    if (RESET) begin
      m_mode = 0; m_cnt = '0; sa1 = 0; sb1 = 0; sa0 = 0; sb0 = 0;
    end else begin
      s1 = sb1; s0 = sb0;
      sb1 = sa1; sa1 = FSMIND1;
      sb0 = sa0; sa0 = FSMIND0ACK;
      case (m_mode)
        0: if (s1) begin m_mode = 1; m_row = 0; m_pos = 0; m_s = eff(Settle); end
        1: if (m_pos == m_s + T + 1) begin
             if (m_row == N - 1) begin m_mode = 2; m_cnt = m_cnt + 32'd1; end
             else begin m_row++; m_pos = 0; m_s = eff(Settle); end
           end else m_pos++;
        default: if (s0 && !s1) m_mode = 0;
      endcase
    end
  endtask

  task automatic tick();
    @(negedge CLK_HS);
    model_step();
    @(posedge CLK_HS);
    #2;
  endtask

  task automatic do_frame(input int settle, input bit keep0, input int chg_row, input int chg_val,
                          input int rst_row, output int t_ack, output int t_frame, output int t_exit);
    Settle = 16'(settle);
    n_start = 0; n_latch = 0;
    foreach (row_len[i]) row_len[i] = 0;
    t_frame = 0; t_exit = 0;
    if (!keep0) FSMIND0ACK = 1'b0;
    FSMIND1 = 1'b1;
    t_ack = 0;
    while (FSMIND1ACK !== 1'b1 && t_ack < 10) begin tick(); t_ack++; end
    chk("ack_seen", FSMIND1ACK, 1);
    chk("first_row", {ROW_EN, ROW_ADDR}, {1'b1, 8'd0});
    while (FSMIND0 !== 1'b1 && t_frame < 6000) begin
      if (chg_row >= 0 && ROW_EN && ROW_ADDR == 8'(chg_row)) Settle = 16'(chg_val);
      if (rst_row >= 0 && ROW_ADDR == 8'(rst_row) && fsm_stat == 8'hF8) begin
        RESET = 1'b1; FSMIND1 = 1'b0;
        tick();
        chk("rst_mid", {ROW_EN, ROW_ADDR, ADC_START, ADC_LATCH, FSMIND0, FSMIND1ACK, fsm_stat, FrameCnt},
            {1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hF1, 32'd0});
        RESET = 1'b0;
        tick();
        return;
      end
      tick(); t_frame++;
    end
    chk("ind0_seen", FSMIND0, 1);
    repeat (4) tick();
    chk("no_early_exit", FSMIND0, 1);
    FSMIND1 = 1'b0;
    if (!keep0) begin
      repeat (5) tick();
      chk("wait_ack0", {FSMIND0, FSMIND1ACK}, 2'b11);
      FSMIND0ACK = 1'b1;
    end
    while (FSMIND0 !== 1'b0 && t_exit < 10) begin tick(); t_exit++; end
    chk("exit_lat", t_exit, 3);
    chk("ack_fall", FSMIND1ACK, 0);
    tick();
  endtask

  initial begin
    int ta, tf, te, good, s;
    bit k;
    repeat (3) tick();
    chk_en = 1'b1;
    tick();
    chk("reset_state", {ROW_EN, ROW_ADDR, ADC_START, ADC_LATCH, FSMIND0, FSMIND1ACK, fsm_stat, FrameCnt},
        {1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hF1, 32'd0});
    RESET = 1'b0;
    repeat (2) tick();

    // full frame, Settle=4, handback with request dropped before FSMIND0ACK
    do_frame(4, 0, -1, 0, -1, ta, tf, te);
    chk("ack_latency", ta, 3);
    chk("frame_len", tf, 3520);
    chk("n_start", n_start, 160);
    chk("n_latch", n_latch, 160);
    good = 0;
    foreach (row_len[i]) if (row_len[i] == 22) good++;
    chk("rows_22", good, 160);
    chk("cnt_1", FrameCnt, 1);

    // Settle=0 acts as 1
    do_frame(0, 0, -1, 0, -1, ta, tf, te);
    chk("s0_row0", row_len[0], 19);
    chk("s0_row159", row_len[159], 19);
    chk("s0_frame", tf, 3040);

    // Settle 4 -> 10 during row 5
    do_frame(4, 0, 5, 10, -1, ta, tf, te);
    chk("chg_row4", row_len[4], 22);
    chk("chg_row5", row_len[5], 22);
    chk("chg_row6", row_len[6], 28);
    chk("chg_frame", tf, 6 * 22 + 154 * 28);
    chk("cnt_3", FrameCnt, 3);

    // reset during CONV of row 37
    do_frame(4, 0, -1, 0, 37, ta, tf, te);
    repeat (3) tick();
    chk("idle_after_rst", {FSMIND1ACK, fsm_stat}, {1'b0, 8'hF1});

    // back-to-back with FSMIND0ACK held high
    FSMIND0ACK = 1'b1;
    Settle = 16'd4;
    repeat (3) tick();
    for (int f = 1; f <= 3; f++) begin
      do_frame(4, 1, -1, 0, -1, ta, tf, te);
      chk("b2b_frame", tf, 3520);
      chk("b2b_cnt", FrameCnt, f);
    end

    // random settle and handshake ordering
    for (int f = 0; f < 2; f++) begin
      s = $urandom_range(0, 6);
      k = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 5)) tick();
      do_frame(s, k, -1, 0, -1, ta, tf, te);
      chk("rand_frame", tf, N * (((s == 0) ? 1 : s) + T + 2));
    end

    // FrameCnt wrap
    force dut.frame_cnt = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    tick();
    release dut.frame_cnt;
    tick();
    chk("preload", FrameCnt, 32'hFFFF_FFFF);
    do_frame(1, 0, -1, 0, -1, ta, tf, te);
    chk("wrap", FrameCnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
